// File: rtl/gj_pkg.sv
// Shared definitions for the Gauss-Jordan inversion sequencer.
//   - row-operation command encodings driven on cmd_op
//   - sequencer FSM state enum
//   - default matrix order and element width
//   - Q16.16 representation of 1.0
package gj_pkg;

  localparam int GJ_DEF_N  = 5;
  localparam int GJ_DEF_DW = 32;

  localparam logic [1:0] GJ_OP_NONE = 2'd0;
  localparam logic [1:0] GJ_OP_NORM = 2'd1;
  localparam logic [1:0] GJ_OP_ELIM = 2'd2;

  localparam logic [31:0] GJ_Q_ONE = 32'h0001_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PIV_RD,
    ST_NORM_ISS,
    ST_NORM_WAIT,
    ST_FAC_RD,
    ST_ELIM_ISS,
    ST_ELIM_WAIT,
    ST_NEXT,
    ST_FIN,
    ST_DONE
  } gj_state_e;

endpackage

// File: rtl/gj_row_iter.sv
// Row iterator for the elimination loop: rows are visited in ascending
// order 0..N-1, skipping the current pivot row p.
// Ports:
//   p     in  RW  current pivot index
//   cur   in  RW  row currently being processed
//   first out RW  first row != p
//   nxt   out RW  next row after cur that is != p (valid when last=0)
//   last  out 1   no row remains after cur
module gj_row_iter #(
  parameter int N  = 5,
  parameter int RW = $clog2(N)
) (
  input  logic [RW-1:0] p,
  input  logic [RW-1:0] cur,
  output logic [RW-1:0] first,
  output logic [RW-1:0] nxt,
  output logic          last
);

  localparam logic [RW:0]   ONE_W   = 1;
  localparam logic [RW:0]   N_W     = (RW+1)'(N);
  localparam logic [RW-1:0] ROW_ONE = 1;

  // One extra bit so the step past row N-1 (and past a skipped p) is
  // representable and can be compared against N.
  logic [RW:0] step1;
  logic [RW:0] step2;

  always_comb begin
    step1 = {1'b0, cur} + ONE_W;
    step2 = (step1 == {1'b0, p}) ? step1 + ONE_W : step1;
  end

  assign first = (p == '0) ? ROW_ONE : '0;
  assign nxt   = step2[RW-1:0];
  assign last  = (step2 >= N_W);

endmodule

// File: rtl/gj_inverse_sequencer.sv
// Control FSM for Gauss-Jordan inversion of an N x 2N augmented matrix.
// For each pivot p it reads the pivot, issues NORM on row p, then for
// every other row r (ascending) reads the factor (r,p) and issues ELIM.
// One command is outstanding at a time; rsp_valid closes it.
// Optional feature (macro GJ_SKIP_ZERO_FACTOR_EN): a zero factor skips
// the ELIM for that row instead of issuing it.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin inversion (accepted in IDLE/DONE only)
//   busy, done, singular  status; singular is sticky until next start
//   cmd_valid/cmd_ready   command handshake; cmd_op/cmd_row/cmd_piv payload
//   rsp_valid             accepted command has been written back
//   rd_row/rd_col/rd_data combinational element read port (left half)
//   op_count              commands accepted since start, saturating at 255
module gj_inverse_sequencer
  import gj_pkg::*;
#(
  parameter int N  = GJ_DEF_N,
  parameter int DW = GJ_DEF_DW,
  parameter int RW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 singular,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_op,
  output logic [RW-1:0]        cmd_row,
  output logic [RW-1:0]        cmd_piv,
  input  logic                 rsp_valid,
  output logic [RW-1:0]        rd_row,
  output logic [RW-1:0]        rd_col,
  input  logic signed [DW-1:0] rd_data,
  output logic [7:0]           op_count
);

  localparam logic [RW-1:0] ROW_ONE  = 1;
  localparam logic [RW-1:0] LAST_PIV = RW'(N-1);

  gj_state_e     state;
  logic [RW-1:0] p;
  logic [RW-1:0] r;
  logic [RW-1:0] first_r;
  logic [RW-1:0] nxt_r;
  logic          last_r;
  logic          rd_zero;
  logic          skip_fac;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  gj_row_iter #(.N(N), .RW(RW)) u_iter (
    .p     (p),
    .cur   (r),
    .first (first_r),
    .nxt   (nxt_r),
    .last  (last_r)
  );

  assign rd_zero = (rd_data == '0);

`ifdef GJ_SKIP_ZERO_FACTOR_EN
  assign skip_fac = rd_zero;
`else
  assign skip_fac = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= GJ_OP_NONE;
      cmd_row   <= '0;
      cmd_piv   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      op_count  <= '0;
      p         <= '0;
      r         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            busy     <= 1'b1;
            singular <= 1'b0;
            op_count <= '0;
            p        <= '0;
            rd_row   <= '0;
            rd_col   <= '0;
            state    <= ST_PIV_RD;
          end
        end
        ST_PIV_RD: begin
          if (rd_zero) begin
            singular <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FIN;
          end else begin
            cmd_valid <= 1'b1;
            cmd_op    <= GJ_OP_NORM;
            cmd_row   <= p;
            cmd_piv   <= p;
            state     <= ST_NORM_ISS;
          end
        end
        ST_NORM_ISS: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            op_count  <= sat_inc(op_count);
            state     <= ST_NORM_WAIT;
          end
        end
        ST_NORM_WAIT: begin
          if (rsp_valid) begin
            r      <= first_r;
            rd_row <= first_r;
            rd_col <= p;
            state  <= ST_FAC_RD;
          end
        end
        ST_FAC_RD: begin
          if (skip_fac) begin
            // Zero factor: the row is already clear in this column.
            if (last_r) begin
              state <= ST_NEXT;
            end else begin
              r      <= nxt_r;
              rd_row <= nxt_r;
            end
          end else begin
            cmd_valid <= 1'b1;
            cmd_op    <= GJ_OP_ELIM;
            cmd_row   <= r;
            cmd_piv   <= p;
            state     <= ST_ELIM_ISS;
          end
        end
        ST_ELIM_ISS: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            op_count  <= sat_inc(op_count);
            state     <= ST_ELIM_WAIT;
          end
        end
        ST_ELIM_WAIT: begin
          if (rsp_valid) begin
            if (last_r) begin
              state <= ST_NEXT;
            end else begin
              r      <= nxt_r;
              rd_row <= nxt_r;
              state  <= ST_FAC_RD;
            end
          end
        end
        ST_NEXT: begin
          if (p == LAST_PIV) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FIN;
          end else begin
            p      <= p + ROW_ONE;
            rd_row <= p + ROW_ONE;
            rd_col <= p + ROW_ONE;
            state  <= ST_PIV_RD;
          end
        end
        ST_FIN: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gj_inverse_sequencer.sv
// Directed bench for gj_inverse_sequencer: an N=5 and an N=2 instance
// share one behavioural row-op unit and matrix store (sel picks the
// active instance). Define GJ_SKIP_ZERO_FACTOR_EN for the skip build.
module tb_gj_inverse_sequencer;
  import gj_pkg::*;

`ifdef GJ_SKIP_ZERO_FACTOR_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cmd_ready, rsp_valid, start5, start2;

  logic       busy5, done5, sing5, cv5;
  logic [1:0] op5;
  logic [2:0] row5, piv5, rdr5, rdc5;
  logic [31:0] rdd5;
  logic [7:0] cnt5;

  logic       busy2, done2, sing2, cv2;
  logic [1:0] op2;
  logic [0:0] row2, piv2, rdr2, rdc2;
  logic [31:0] rdd2;
  logic [7:0] cnt2;

  gj_inverse_sequencer #(.N(5), .DW(32)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .busy(busy5), .done(done5),
    .singular(sing5), .cmd_valid(cv5), .cmd_ready(cmd_ready), .cmd_op(op5),
    .cmd_row(row5), .cmd_piv(piv5), .rsp_valid(rsp_valid), .rd_row(rdr5),
    .rd_col(rdc5), .rd_data(rdd5), .op_count(cnt5)
  );

  gj_inverse_sequencer #(.N(2), .DW(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .singular(sing2), .cmd_valid(cv2), .cmd_ready(cmd_ready), .cmd_op(op2),
    .cmd_row(row2), .cmd_piv(piv2), .rsp_valid(rsp_valid), .rd_row(rdr2),
    .rd_col(rdc2), .rd_data(rdd2), .op_count(cnt2)
  );

  // Behavioural row-op unit and matrix store
  logic signed [31:0] mem [0:7][0:15];
  logic signed [31:0] src [0:7][0:15];
  logic       load;
  logic       sel;
  logic       mv;
  logic [1:0] mop;
  int         mrow, mpiv, nn;
  logic       pend;
  int         lat;
  logic [1:0] q_op;
  int         q_row, q_piv;
  int         log_cmd [0:63];
  int         log_n = 0;
  int         done_cnt = 0;

  assign rdd5 = mem[rdr5][rdc5];
  assign rdd2 = mem[rdr2][rdc2];

  always_comb begin
    if (sel) begin
      mv = cv2; mop = op2; mrow = int'(row2); mpiv = int'(piv2); nn = 2;
    end else begin
      mv = cv5; mop = op5; mrow = int'(row5); mpiv = int'(piv5); nn = 5;
    end
  end

  always @(posedge clk) begin
    if (sel ? done2 : done5) done_cnt <= done_cnt + 1;
    if (!rst_n) begin
      pend      <= 1'b0;
      lat       <= 0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (load) begin
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 16; c++) mem[r][c] <= src[r][c];
      end
      if (pend) begin
        if (lat > 0) begin
          lat <= lat - 1;
        end else begin
          for (int c = 0; c < 2 * nn; c++) begin
            if (q_op == GJ_OP_NORM)
              mem[q_row][c] <= 32'((longint'(mem[q_row][c]) <<< 16) / longint'(mem[q_row][q_piv]));
            else
              mem[q_row][c] <= mem[q_row][c] -
                32'((longint'(mem[q_row][q_piv]) * longint'(mem[q_piv][c])) >>> 16);
          end
          rsp_valid <= 1'b1;
          pend      <= 1'b0;
        end
      end
      if (mv && cmd_ready) begin
        pend  <= 1'b1;
        lat   <= 2;
        q_op  <= mop;
        q_row <= mrow;
        q_piv <= mpiv;
        if (log_n < 64) log_cmd[log_n] <= int'(mop) * 256 + mrow * 16 + mpiv;
        log_n <= log_n + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int enc(input int op, input int row, input int piv);
    return op * 256 + row * 16 + piv;
  endfunction

  task automatic check_seq(input int base, input int n, input bit norm_only);
    int k;
    k = base;
    for (int p = 0; p < n; p++) begin
      check("seq_norm", (k < 64) ? log_cmd[k] : -1, enc(1, p, p));
      k++;
      if (!norm_only) begin
        for (int r = 0; r < n; r++) begin
          if (r != p) begin
            check("seq_elim", (k < 64) ? log_cmd[k] : -1, enc(2, r, p));
            k++;
          end
        end
      end
    end
  endtask

  task automatic pulse_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic load_identity5();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) src[r][c] = '0;
    for (int r = 0; r < 5; r++) begin
      src[r][r]     = GJ_Q_ONE;
      src[r][5 + r] = GJ_Q_ONE;
    end
    pulse_load();
  endtask

  task automatic load_2x2(input int a00, input int a01, input int a10, input int a11);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) src[r][c] = '0;
    src[0][0] = 32'(a00 * 65536);
    src[0][1] = 32'(a01 * 65536);
    src[1][0] = 32'(a10 * 65536);
    src[1][1] = 32'(a11 * 65536);
    src[0][2] = GJ_Q_ONE;
    src[1][3] = GJ_Q_ONE;
    pulse_load();
  endtask

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start2 = 1'b1; else start5 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start5 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (which ? done2 : done5) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_good_2x2(input int base, input int dbase);
    check("c_count", log_n - base, 4);
    check_seq(base, 2, 1'b0);
    check("c_opcnt", cnt2, 4);
    check("c_singular", sing2, 0);
    check("c_busy", busy2, 0);
    check("c_done_pulses", done_cnt - dbase, 1);
    check("c_l00", mem[0][0], 65536);
    check("c_l01", mem[0][1], 0);
    check("c_l10", mem[1][0], 0);
    check("c_l11", mem[1][1], 65536);
    check("c_r00", mem[0][2], 98304);
    check("c_r01", mem[0][3], -32768);
    check("c_r10", mem[1][2], -131072);
    check("c_r11", mem[1][3], 65536);
  endtask

  initial begin
    int base, dbase;
    bit seen;
    rst_n = 1'b0; start5 = 1'b0; start2 = 1'b0;
    cmd_ready = 1'b1; load = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy5, 0);
    check("rst_done", done5, 0);
    check("rst_singular", sing5, 0);
    check("rst_cmd_valid", cv5, 0);
    check("rst_cmd_op", op5, 0);
    check("rst_cmd_row", row5, 0);
    check("rst_cmd_piv", piv5, 0);
    check("rst_rd_row", rdr5, 0);
    check("rst_rd_col", rdc5, 0);
    check("rst_op_count", cnt5, 0);
    check("rst_busy2", busy2, 0);
    rst_n = 1'b1;

    // Identity N=5, first command stalled 10 cycles, start pulsed while busy
    load_identity5();
    cmd_ready = 1'b0;
    base = log_n; dbase = done_cnt;
    pulse_start(1'b0);
    check("a_busy_after_start", busy5, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cv5) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("a_cmd_valid_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      check("a_stall_valid", cv5, 1);
      check("a_stall_cmd", enc(int'(op5), int'(row5), int'(piv5)), enc(1, 0, 0));
      start5 = (i == 3);
      @(negedge clk);
    end
    start5 = 1'b0;
    check("a_stall_accepts", log_n - base, 0);
    cmd_ready = 1'b1;
    wait_done(1'b0, 3000);
    check("a_count", log_n - base, SKIP ? 5 : 25);
    check_seq(base, 5, SKIP);
    check("a_opcnt", cnt5, SKIP ? 5 : 25);
    check("a_singular", sing5, 0);
    check("a_busy", busy5, 0);
    check("a_done_pulses", done_cnt - dbase, 1);
    check("a_inv00", mem[0][5], 65536);
    check("a_inv44", mem[4][9], 65536);

    // N=2 singular [[1,2],[2,4]]
    sel = 1'b1;
    load_2x2(1, 2, 2, 4);
    base = log_n; dbase = done_cnt;
    pulse_start(1'b1);
    wait_done(1'b1, 1000);
    check("b_count", log_n - base, 2);
    check("b_seq0", log_cmd[base], enc(1, 0, 0));
    check("b_seq1", log_cmd[base + 1], enc(2, 1, 0));
    check("b_opcnt", cnt2, 2);
    check("b_singular", sing2, 1);
    check("b_busy", busy2, 0);
    check("b_done_pulses", done_cnt - dbase, 1);

    // N=2 invertible [[2,1],[4,3]]; also confirms singular is cleared
    load_2x2(2, 1, 4, 3);
    base = log_n; dbase = done_cnt;
    pulse_start(1'b1);
    check("c_singular_cleared", sing2, 0);
    wait_done(1'b1, 1000);
    check_good_2x2(base, dbase);

    // Reset while the first ELIM is outstanding, then a clean rerun
    load_2x2(2, 1, 4, 3);
    base = log_n;
    pulse_start(1'b1);
    for (int i = 0; i < 200 && (log_n - base) < 2; i++) @(negedge clk);
    check("d_reached_elim", log_n - base, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("d_rst_busy", busy2, 0);
    check("d_rst_cmd_valid", cv2, 0);
    check("d_rst_opcnt", cnt2, 0);
    check("d_rst_done", done2, 0);
    rst_n = 1'b1;
    load_2x2(2, 1, 4, 3);
    base = log_n; dbase = done_cnt;
    pulse_start(1'b1);
    wait_done(1'b1, 1000);
    check_good_2x2(base, dbase);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
